// File: rtl/fir_xifu_mem_responder.sv
// Core-side XIF mem/mem_result responder: checks each coprocessor memory request,
// forwards legal ones to a single OBI data port and returns OBI responses in order.
module fir_xifu_mem_responder #(
    parameter int unsigned X_ID_WIDTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] ADDR_BASE       = 32'h1000_0000,
    parameter logic [31:0] ADDR_SIZE       = 32'h0001_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    // XIF memory request / response
    input  logic                  x_mem_valid_i,
    output logic                  x_mem_ready_o,
    input  logic [X_ID_WIDTH-1:0] x_mem_id_i,
    input  logic [31:0]           x_mem_addr_i,
    input  logic                  x_mem_we_i,
    input  logic [2:0]            x_mem_size_i,
    input  logic [3:0]            x_mem_be_i,
    input  logic [31:0]           x_mem_wdata_i,
    output logic                  x_mem_resp_exc_o,
    output logic [5:0]            x_mem_resp_exccode_o,
    // XIF memory result
    output logic                  x_mem_result_valid_o,
    output logic [X_ID_WIDTH-1:0] x_mem_result_id_o,
    output logic [31:0]           x_mem_result_rdata_o,
    output logic                  x_mem_result_err_o,
    // OBI data port
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [31:0]           data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    // 33-bit bounds so a window ending at 4 GiB does not wrap
    localparam logic [32:0] BASE_33 = {1'b0, ADDR_BASE};
    localparam logic [32:0] END_33  = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

    localparam logic [5:0] EXC_LOAD_MISALIGN  = 6'd4;
    localparam logic [5:0] EXC_LOAD_FAULT     = 6'd5;
    localparam logic [5:0] EXC_STORE_MISALIGN = 6'd6;
    localparam logic [5:0] EXC_STORE_FAULT    = 6'd7;

    logic                  w_misaligned;
    logic                  w_in_range;
    logic                  w_legal;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [X_ID_WIDTH-1:0] w_head_id;
    logic                  w_head_we;

    logic [X_ID_WIDTH-1:0] r_fifo_id [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] r_fifo_we;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_cnt;

    logic                  r_res_valid;
    logic [X_ID_WIDTH-1:0] r_res_id;
    logic [31:0]           r_res_rdata;
    logic                  r_res_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Sizes above word are illegal and reported as misaligned
    always_comb begin
        w_misaligned = 1'b0;
        case (x_mem_size_i)
            3'd0:    w_misaligned = 1'b0;
            3'd1:    w_misaligned = x_mem_addr_i[0];
            3'd2:    w_misaligned = |x_mem_addr_i[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    assign w_in_range = ({1'b0, x_mem_addr_i} >= BASE_33) && ({1'b0, x_mem_addr_i} < END_33);
    assign w_legal    = ~w_misaligned & w_in_range;

    always_comb begin
        x_mem_resp_exc_o     = 1'b0;
        x_mem_resp_exccode_o = 6'd0;
        if (x_mem_valid_i) begin
            if (w_misaligned) begin
                x_mem_resp_exc_o     = 1'b1;
                x_mem_resp_exccode_o = x_mem_we_i ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
            end else if (!w_in_range) begin
                x_mem_resp_exc_o     = 1'b1;
                x_mem_resp_exccode_o = x_mem_we_i ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
            end
        end
    end

    assign w_full  = (r_cnt == FULL_CNT);
    assign w_empty = (r_cnt == '0);

    assign data_req_o    = x_mem_valid_i & w_legal & ~w_full;
    assign data_addr_o   = {x_mem_addr_i[31:2], 2'b00};
    assign data_we_o     = x_mem_we_i;
    assign data_be_o     = x_mem_be_i;
    assign data_wdata_o  = x_mem_wdata_i;
    assign x_mem_ready_o = x_mem_resp_exc_o | (data_req_o & data_gnt_i);

    assign w_push    = data_req_o & data_gnt_i & ~clear_i;
    assign w_pop     = data_rvalid_i & ~w_empty & ~clear_i;
    assign w_head_id = r_fifo_id[r_rptr];
    assign w_head_we = r_fifo_we[r_rptr];

    // Payload storage needs no reset: only entries below r_cnt are ever read
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_id[r_wptr] <= x_mem_id_i;
            r_fifo_we[r_wptr] <= x_mem_we_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_rdata <= '0;
            r_res_err   <= 1'b0;
        end else if (clear_i) begin
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= w_pop;
            if (w_pop) begin
                r_res_id    <= w_head_id;
                r_res_rdata <= w_head_we ? 32'd0 : data_rdata_i;
                r_res_err   <= data_err_i;
            end
        end
    end

    assign x_mem_result_valid_o = r_res_valid;
    assign x_mem_result_id_o    = r_res_id;
    assign x_mem_result_rdata_o = r_res_rdata;
    assign x_mem_result_err_o   = r_res_err;

    // OBI responses with nothing outstanding, and flushes mid-transaction, are protocol errors
    a_rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(data_rvalid_i && w_empty))
        else $error("rvalid with no outstanding request");

    a_clear_when_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(clear_i && !w_empty))
        else $error("clear asserted with OBI transaction outstanding");

endmodule

// File: tb/tb_fir_xifu_mem_responder.sv
// Directed bench for fir_xifu_mem_responder: exception vector table plus
// hand-written multi-cycle OBI sequences.
module tb_fir_xifu_mem_responder;

    logic        clk_i, rst_ni, clear_i;
    logic        x_mem_valid_i, x_mem_ready_o;
    logic [3:0]  x_mem_id_i;
    logic [31:0] x_mem_addr_i;
    logic        x_mem_we_i;
    logic [2:0]  x_mem_size_i;
    logic [3:0]  x_mem_be_i;
    logic [31:0] x_mem_wdata_i;
    logic        x_mem_resp_exc_o;
    logic [5:0]  x_mem_resp_exccode_o;
    logic        x_mem_result_valid_o;
    logic [3:0]  x_mem_result_id_o;
    logic [31:0] x_mem_result_rdata_o;
    logic        x_mem_result_err_o;
    logic        data_req_o, data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    int checks   = 0;
    int failures = 0;

    fir_xifu_mem_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o),
        .x_mem_id_i(x_mem_id_i), .x_mem_addr_i(x_mem_addr_i), .x_mem_we_i(x_mem_we_i),
        .x_mem_size_i(x_mem_size_i), .x_mem_be_i(x_mem_be_i), .x_mem_wdata_i(x_mem_wdata_i),
        .x_mem_resp_exc_o(x_mem_resp_exc_o), .x_mem_resp_exccode_o(x_mem_resp_exccode_o),
        .x_mem_result_valid_o(x_mem_result_valid_o), .x_mem_result_id_o(x_mem_result_id_o),
        .x_mem_result_rdata_o(x_mem_result_rdata_o), .x_mem_result_err_o(x_mem_result_err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic        we;
        logic [2:0]  size;
        logic        exc;
        logic [5:0]  code;
        logic        req;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        x_mem_valid_i = 1'b0; x_mem_id_i = '0; x_mem_addr_i = '0; x_mem_we_i = 1'b0;
        x_mem_size_i = '0; x_mem_be_i = '0; x_mem_wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                       input logic [2:0] size);
        x_mem_valid_i = 1'b1; x_mem_id_i = id; x_mem_addr_i = addr;
        x_mem_we_i = we; x_mem_size_i = size; x_mem_be_i = 4'hF;
    endtask

    logic [3:0] bb_ids  [6];
    logic       bb_ready[6];

    initial begin
        vecs[0]  = '{1'b1, 32'h1000_0004, 1'b0, 3'd2, 1'b0, 6'd0, 1'b1};
        vecs[1]  = '{1'b1, 32'h1000_0002, 1'b1, 3'd2, 1'b1, 6'd6, 1'b0};
        vecs[2]  = '{1'b1, 32'h0FFF_FFFC, 1'b0, 3'd2, 1'b1, 6'd5, 1'b0};
        vecs[3]  = '{1'b1, 32'h1001_0000, 1'b0, 3'd2, 1'b1, 6'd5, 1'b0};
        vecs[4]  = '{1'b1, 32'h1000_FFFC, 1'b0, 3'd2, 1'b0, 6'd0, 1'b1};
        vecs[5]  = '{1'b1, 32'h1000_0000, 1'b1, 3'd3, 1'b1, 6'd6, 1'b0};
        vecs[6]  = '{1'b1, 32'h1000_0001, 1'b0, 3'd1, 1'b1, 6'd4, 1'b0};
        vecs[7]  = '{1'b1, 32'h1000_0003, 1'b1, 3'd0, 1'b0, 6'd0, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0001, 1'b1, 3'd1, 1'b1, 6'd6, 1'b0};
        vecs[9]  = '{1'b1, 32'h2000_0000, 1'b1, 3'd2, 1'b1, 6'd7, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0003, 1'b1, 3'd7, 1'b0, 6'd0, 1'b0};

        bb_ids   = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
        bb_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        idle_inputs();
        rst_ni = 1'b0;
        #12;
        chk("rst_ready", 32'(x_mem_ready_o), 32'd0);
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_exc", 32'(x_mem_resp_exc_o), 32'd0);
        chk("rst_res_valid", 32'(x_mem_result_valid_o), 32'd0);
        chk("rst_res_id", 32'(x_mem_result_id_o), 32'd0);
        chk("rst_res_rdata", x_mem_result_rdata_o, 32'd0);
        chk("rst_res_err", 32'(x_mem_result_err_o), 32'd0);
        #1 rst_ni = 1'b1;

        // Combinational exception table, gnt held low so nothing is accepted
        for (int i = 0; i < 11; i++) begin
            step();
            x_mem_valid_i = vecs[i].valid; x_mem_addr_i = vecs[i].addr;
            x_mem_we_i = vecs[i].we; x_mem_size_i = vecs[i].size; x_mem_id_i = 4'(i);
            #1;
            chk($sformatf("vec%0d_exc", i), 32'(x_mem_resp_exc_o), 32'(vecs[i].exc));
            chk($sformatf("vec%0d_code", i), 32'(x_mem_resp_exccode_o), 32'(vecs[i].code));
            chk($sformatf("vec%0d_ready", i), 32'(x_mem_ready_o), 32'(vecs[i].exc));
            chk($sformatf("vec%0d_req", i), 32'(data_req_o), 32'(vecs[i].req));
        end
        step();
        idle_inputs();

        // Aligned load, zero-wait memory: accepted in cycle 0, result in cycle 2
        step();
        req(4'd3, 32'h1000_0004, 1'b0, 3'd2);
        data_gnt_i = 1'b1;
        #1;
        chk("a_ready", 32'(x_mem_ready_o), 32'd1);
        chk("a_req", 32'(data_req_o), 32'd1);
        chk("a_addr", data_addr_o, 32'h1000_0004);
        step();
        idle_inputs();
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("a_res_early", 32'(x_mem_result_valid_o), 32'd0);
        step();
        idle_inputs();
        #1;
        chk("a_res_valid", 32'(x_mem_result_valid_o), 32'd1);
        chk("a_res_id", 32'(x_mem_result_id_o), 32'd3);
        chk("a_res_rdata", x_mem_result_rdata_o, 32'hDEAD_BEEF);
        chk("a_res_err", 32'(x_mem_result_err_o), 32'd0);
        step();
        chk("a_res_once", 32'(x_mem_result_valid_o), 32'd0);

        // Misaligned store: immediate exception, no OBI traffic, no result
        step();
        req(4'd4, 32'h1000_0002, 1'b1, 3'd2);
        data_gnt_i = 1'b1;
        #1;
        chk("b_exc", 32'(x_mem_resp_exc_o), 32'd1);
        chk("b_code", 32'(x_mem_resp_exccode_o), 32'd6);
        chk("b_ready", 32'(x_mem_ready_o), 32'd1);
        chk("b_req", 32'(data_req_o), 32'd0);
        step();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("b_nores%0d", c), 32'(x_mem_result_valid_o), 32'd0);
        end

        // Access at the last word of the window goes through to OBI
        step();
        req(4'd2, 32'h1000_FFFC, 1'b0, 3'd2);
        data_gnt_i = 1'b1;
        #1;
        chk("c_ready", 32'(x_mem_ready_o), 32'd1);
        chk("c_addr", data_addr_o, 32'h1000_FFFC);
        step();
        idle_inputs();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0000_0777;
        step();
        idle_inputs();
        #1;
        chk("c_res_id", 32'(x_mem_result_id_o), 32'd2);
        chk("c_res_rdata", x_mem_result_rdata_o, 32'h0000_0777);

        // Back-to-back loads, 2-deep FIFO, rvalid 3 cycles after acceptance
        for (int c = 0; c < 12; c++) begin
            step();
            idle_inputs();
            data_gnt_i = 1'b1;
            if (c < 6) req(bb_ids[c], 32'h1000_0100 + 32'(4 * bb_ids[c]), 1'b0, 3'd2);
            case (c)
                3: begin data_rvalid_i = 1'b1; data_rdata_i = 32'h100; end
                4: begin data_rvalid_i = 1'b1; data_rdata_i = 32'h101; end
                7: begin data_rvalid_i = 1'b1; data_rdata_i = 32'h102; end
                8: begin data_rvalid_i = 1'b1; data_rdata_i = 32'h103; end
                default: ;
            endcase
            #1;
            if (c < 6) begin
                chk($sformatf("d_ready_c%0d", c), 32'(x_mem_ready_o), 32'(bb_ready[c]));
                chk($sformatf("d_req_c%0d", c), 32'(data_req_o), 32'(bb_ready[c]));
            end
            case (c)
                4, 5, 8, 9: begin
                    int k;
                    k = (c < 6) ? c - 4 : c - 6;
                    chk($sformatf("d_res_valid_c%0d", c), 32'(x_mem_result_valid_o), 32'd1);
                    chk($sformatf("d_res_id_c%0d", c), 32'(x_mem_result_id_o), 32'(k));
                    chk($sformatf("d_res_rdata_c%0d", c), x_mem_result_rdata_o, 32'h100 + 32'(k));
                end
                default:
                    chk($sformatf("d_res_valid_c%0d", c), 32'(x_mem_result_valid_o), 32'd0);
            endcase
        end
        step();
        idle_inputs();

        // Grant withheld for 4 cycles: request held stable, single push
        for (int c = 0; c < 5; c++) begin
            step();
            req(4'd5, 32'h1000_0012, 1'b0, 3'd1);
            data_gnt_i = (c == 4);
            #1;
            chk($sformatf("e_req_c%0d", c), 32'(data_req_o), 32'd1);
            chk($sformatf("e_addr_c%0d", c), data_addr_o, 32'h1000_0010);
            chk($sformatf("e_ready_c%0d", c), 32'(x_mem_ready_o), (c == 4) ? 32'd1 : 32'd0);
        end
        step();
        idle_inputs();
        #1;
        chk("e_req_drop", 32'(data_req_o), 32'd0);
        step();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h55;
        step();
        idle_inputs();
        #1;
        chk("e_res_valid", 32'(x_mem_result_valid_o), 32'd1);
        chk("e_res_id", 32'(x_mem_result_id_o), 32'd5);

        // Store with bus error, then flush and a fresh load
        step();
        req(4'd7, 32'h1000_0008, 1'b1, 3'd2);
        x_mem_be_i = 4'hC; x_mem_wdata_i = 32'h0000_CAFE;
        data_gnt_i = 1'b1;
        #1;
        chk("f_we", 32'(data_we_o), 32'd1);
        chk("f_be", 32'(data_be_o), 32'hC);
        chk("f_wdata", data_wdata_o, 32'h0000_CAFE);
        chk("f_ready", 32'(x_mem_ready_o), 32'd1);
        step();
        idle_inputs();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678; data_err_i = 1'b1;
        step();
        idle_inputs();
        #1;
        chk("f_res_valid", 32'(x_mem_result_valid_o), 32'd1);
        chk("f_res_id", 32'(x_mem_result_id_o), 32'd7);
        chk("f_res_rdata", x_mem_result_rdata_o, 32'd0);
        chk("f_res_err", 32'(x_mem_result_err_o), 32'd1);
        step();
        clear_i = 1'b1;
        step();
        idle_inputs();
        #1;
        chk("f_clr_res", 32'(x_mem_result_valid_o), 32'd0);
        step();
        req(4'd9, 32'h1000_0020, 1'b0, 3'd2);
        data_gnt_i = 1'b1;
        #1;
        chk("f_new_ready", 32'(x_mem_ready_o), 32'd1);
        step();
        idle_inputs();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h0000_A5A5;
        step();
        idle_inputs();
        #1;
        chk("f_new_valid", 32'(x_mem_result_valid_o), 32'd1);
        chk("f_new_id", 32'(x_mem_result_id_o), 32'd9);
        chk("f_new_rdata", x_mem_result_rdata_o, 32'h0000_A5A5);
        chk("f_new_err", 32'(x_mem_result_err_o), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_xifu_mem_responder.md
Name: fir_xifu_mem_responder

Overview:
- Core-side responder for the XIF memory and memory-result channels. It is the counterpart of the coprocessor's mem request / mem_result ports.
- Accepts coprocessor memory requests and answers each one in the same cycle with a mem_resp (exception or OK).
- Forwards non-excepting requests to a single OBI data port and returns the OBI responses, in order, as mem_result.
- Used in the standalone FIR-XIFU testbench system and as a core-side stub wherever the coprocessor runs without a full CV32E40X LSU.

Parameters:
- X_ID_WIDTH, 4, width of the XIF instruction id.
- MAX_OUTSTANDING, 2, depth of the outstanding-id FIFO; must be a power of 2, ≥1.
- ADDR_BASE, 32'h1000_0000, first legal byte address.
- ADDR_SIZE, 32'h0001_0000, size of the legal window in bytes.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- clear_i  in  1  synchronous flush of FIFO and result register
- x_mem_valid_i  in  1  request valid
- x_mem_ready_o  out  1  request accepted
- x_mem_id_i  in  X_ID_WIDTH  request id
- x_mem_addr_i  in  32  byte address
- x_mem_we_i  in  1  1 = store
- x_mem_size_i  in  3  log2 access bytes (0,1,2 legal)
- x_mem_be_i  in  4  byte enables
- x_mem_wdata_i  in  32  store data
- x_mem_resp_exc_o  out  1  request raised an exception
- x_mem_resp_exccode_o  out  6  exception code
- x_mem_result_valid_o  out  1  result valid (no ready)
- x_mem_result_id_o  out  X_ID_WIDTH  result id
- x_mem_result_rdata_o  out  32  load data (0 for stores)
- x_mem_result_err_o  out  1  bus error
- data_req_o  out  1  OBI request
- data_gnt_i  in  1  OBI grant
- data_addr_o  out  32  OBI address, word-aligned
- data_we_o  out  1  OBI write enable
- data_be_o  out  4  OBI byte enables
- data_wdata_o  out  32  OBI write data
- data_rvalid_i  in  1  OBI response valid
- data_rdata_i  in  32  OBI read data
- data_err_i  in  1  OBI error

Behaviour:
- Reset is asynchronous and active-low on rst_ni; the block has a single clock, clk_i.
- Reset values: all outputs 0, FIFO empty, result register invalid.
- Exception check is combinational on the request fields. Priority, highest first:
  - size > 2 → illegal; treated as misaligned.
  - misaligned, i.e. addr[size-1:0] != 0 → exccode 6 (store) or 4 (load).
  - addr outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) → exccode 7 (store) or 5 (load).
- x_mem_resp_exc_o and x_mem_resp_exccode_o are combinational. They are valid whenever x_mem_valid_i=1 and are 0 otherwise.
- Excepting request:
  - x_mem_ready_o=1 in the same cycle, regardless of FIFO state.
  - No OBI request is issued, nothing is pushed to the FIFO, and no mem_result is ever produced for it.
- Legal request:
  - data_req_o = x_mem_valid_i & !fifo_full.
  - data_addr_o = {addr[31:2], 2'b00}; be, we and wdata pass straight through.
  - x_mem_ready_o = data_req_o & data_gnt_i, so a combinational gnt→ready path is permitted.
  - On acceptance, push {id, we} into the FIFO.
  - While gnt is low, the XIF request must stay stable (XIF rule). The responder holds data_req_o high and never retracts it.
- FIFO full: data_req_o=0 and x_mem_ready_o=0 for legal requests. There is no same-cycle pop bypass.
- Response path:
  - data_rvalid_i pops the FIFO head. On the next rising edge it registers result_valid=1, id=head.id, rdata = head.we ? 0 : data_rdata_i, err=data_err_i.
  - x_mem_result_valid_o is high for exactly one cycle per response. Responses return in request order.
  - Latency: rvalid in cycle N → result_valid in cycle N+1. With a zero-wait-state memory (gnt same cycle, rvalid next cycle), request accepted in cycle 0 → result in cycle 2.
- Simultaneous push and pop: both take effect and the count is unchanged. Legal only if not full before the edge.
- data_rvalid_i while the FIFO is empty is a protocol violation. It is ignored, nothing is produced, and a simulation assertion fires.
- clear_i (synchronous) empties the FIFO and drops the result register; it has priority over push and pop. It must only be asserted when no OBI transaction is outstanding; an assertion checks this.
- Reset mid-transaction drops all state. The memory is expected to be reset together with the block.

Test Plan:
- Aligned load, addr 0x1000_0004, size 2, id 3; gnt same cycle; rvalid next cycle with rdata 0xDEADBEEF → ready in cycle 0, result_valid in cycle 2 with id 3, rdata 0xDEADBEEF, err 0.
- Store, addr 0x1000_0002, size 2 → exc=1, exccode 6, ready=1 same cycle, data_req_o never high, no result.
- Load at 0x0FFF_FFFC, then at 0x1001_0000 → exccode 5 each. Load at 0x1000_FFFC → legal.
- Four back-to-back loads with ids 0..3, MAX_OUTSTANDING=2, rvalid delayed 3 cycles → ready drops after 2 accepts; results come out in order 0,1,2,3; FIFO never overflows.
- gnt held low for 4 cycles → data_req_o stays high and stable, ready low until gnt; exactly one FIFO push.
- Store with data_err_i=1 → result err=1, rdata 0. Then assert clear_i while idle, followed by a fresh load → normal result with no stale id.
